// File: rtl/hamsi_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : hamsi_round_engine
//  Description : Iterative Hamsi compression core. Loads one expanded message
//                block plus the chaining value into a 16-word state, runs one
//                round (addition, substitution, diffusion) per clock, then
//                truncates and feeds the result forward into the chaining value.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamsi_round_engine #(
    parameter int ROUNDS   = 3,
    parameter int ROUNDS_F = 6,
    parameter int CNT_W    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_final,
    input  logic [255:0] exp_in,
    input  logic [255:0] iv_in,
    input  logic [511:0] alpha_n,
    input  logic [511:0] alpha_f,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] hash_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter value of the final round for each compression mode
    localparam logic [CNT_W-1:0] c_LAST_N = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] c_LAST_F = CNT_W'(ROUNDS_F - 1);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_s [16];
    logic [255:0]     r_h;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fin;

    logic [511:0]     w_alpha;
    logic [31:0]      w_cnt_ext;
    logic [31:0]      w_a  [16];
    logic [31:0]      w_sb [16];
    logic [31:0]      w_l  [16];
    logic [3:0]       w_nib;
    logic [255:0]     w_chain;
    logic [255:0]     w_trunc;
    logic             w_last;

    // 4-bit Hamsi S-box; nibble bit k comes from / goes to column word k
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h8;  4'h1: y = 4'h6;  4'h2: y = 4'h7;  4'h3: y = 4'h9;
            4'h4: y = 4'h3;  4'h5: y = 4'hC;  4'h6: y = 4'hA;  4'h7: y = 4'hF;
            4'h8: y = 4'hD;  4'h9: y = 4'h1;  4'hA: y = 4'hE;  4'hB: y = 4'h4;
            4'hC: y = 4'h0;  4'hD: y = 4'hB;  4'hE: y = 4'h5;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Diffusion on one (a,b,c,d) quadruple, result packed as {d,c,b,a}
    function automatic logic [127:0] mix(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] ta, tb, tc, td;
        ta = rotl(a, 13);
        tc = rotl(c, 3);
        tb = b ^ ta ^ tc;
        td = d ^ tc ^ (ta << 3);
        tb = rotl(tb, 1);
        td = rotl(td, 7);
        ta = ta ^ tb ^ td;
        tc = tc ^ td ^ (tb << 7);
        ta = rotl(ta, 5);
        tc = rotl(tc, 22);
        return {td, tc, tb, ta};
    endfunction

    assign w_alpha   = r_fin ? alpha_f : alpha_n;
    assign w_cnt_ext = 32'(r_cnt);
    assign w_chain   = in_first ? iv_in : r_h;
    assign w_last    = (r_cnt == (r_fin ? c_LAST_F : c_LAST_N));
    assign w_trunc   = {w_l[11], w_l[10], w_l[9], w_l[8], w_l[3], w_l[2], w_l[1], w_l[0]};

    // Constant addition; the round counter only perturbs word 1
    for (genvar i = 0; i < 16; i++) begin : g_add
        assign w_a[i] = r_s[i] ^ w_alpha[32*i +: 32] ^ ((i == 1) ? w_cnt_ext : 32'd0);
    end

    // Bit-sliced substitution over columns (s_i, s_i+4, s_i+8, s_i+12)
    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_sb[i] = 32'd0;
        end
        for (int col = 0; col < 4; col++) begin
            for (int b = 0; b < 32; b++) begin
                w_nib = sbox({w_a[col+12][b], w_a[col+8][b], w_a[col+4][b], w_a[col][b]});
                w_sb[col][b]    = w_nib[0];
                w_sb[col+4][b]  = w_nib[1];
                w_sb[col+8][b]  = w_nib[2];
                w_sb[col+12][b] = w_nib[3];
            end
        end
    end

    // Diffusion over the diagonal quadruples (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14)
    for (genvar j = 0; j < 4; j++) begin : g_mix
        localparam int IA = j;
        localparam int IB = 4 + ((j + 1) % 4);
        localparam int IC = 8 + ((j + 2) % 4);
        localparam int ID = 12 + ((j + 3) % 4);
        assign {w_l[ID], w_l[IC], w_l[IB], w_l[IA]} =
            mix(w_sb[IA], w_sb[IB], w_sb[IC], w_sb[ID]);
    end

    // Control FSM, state words, chaining value and handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_h         <= '0;
            r_cnt       <= '0;
            r_fin       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_s[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_s[0]     <= exp_in[31:0];
                        r_s[1]     <= exp_in[63:32];
                        r_s[2]     <= w_chain[31:0];
                        r_s[3]     <= w_chain[63:32];
                        r_s[4]     <= w_chain[95:64];
                        r_s[5]     <= w_chain[127:96];
                        r_s[6]     <= exp_in[95:64];
                        r_s[7]     <= exp_in[127:96];
                        r_s[8]     <= exp_in[159:128];
                        r_s[9]     <= exp_in[191:160];
                        r_s[10]    <= w_chain[159:128];
                        r_s[11]    <= w_chain[191:160];
                        r_s[12]    <= w_chain[223:192];
                        r_s[13]    <= w_chain[255:224];
                        r_s[14]    <= exp_in[223:192];
                        r_s[15]    <= exp_in[255:224];
                        r_h        <= w_chain;
                        r_fin      <= in_final;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    for (int i = 0; i < 16; i++) begin
                        r_s[i] <= w_l[i];
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_h         <= r_h ^ w_trunc;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign hash_out  = r_h;

endmodule
`default_nettype wire

// File: tb/tb_hamsi_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamsi_round_engine
//  Description : Directed self-checking bench for hamsi_round_engine with a
//                behavioural golden model of the Hamsi compression.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hamsi_round_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_first, in_final, out_ready;
    logic [255:0] exp_in, iv_in;
    logic [511:0] alpha_n, alpha_f;
    logic         in_ready, out_valid;
    logic [255:0] hash_out;
    logic         in_valid7, out_ready7, in_ready7, out_valid7;
    logic [255:0] hash_out7;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [255:0] model_h;
    logic [3:0]   sb_tbl [16];

    always #5 clk = ~clk;

    hamsi_round_engine #(.ROUNDS(3), .ROUNDS_F(6), .CNT_W(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_final(in_final), .exp_in(exp_in), .iv_in(iv_in),
        .alpha_n(alpha_n), .alpha_f(alpha_f), .out_valid(out_valid),
        .out_ready(out_ready), .hash_out(hash_out)
    );

    hamsi_round_engine #(.ROUNDS(3), .ROUNDS_F(7), .CNT_W(3)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7),
        .in_first(in_first), .in_final(in_final), .exp_in(exp_in), .iv_in(iv_in),
        .alpha_n(alpha_n), .alpha_f(alpha_f), .out_valid(out_valid7),
        .out_ready(out_ready7), .hash_out(hash_out7)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Golden model: returns c ^ T(P(s)) for message m and chaining value c
    function automatic logic [255:0] model_compress(input logic [255:0] m, input logic [255:0] c,
                                                    input logic [511:0] al, input int rounds);
        logic [31:0] s [16];
        logic [31:0] t [16];
        logic [3:0]  v;
        logic [31:0] a, b, cc, d;
        int          ia, ib, ic, id;
        s[0]  = m[31:0];    s[1]  = m[63:32];   s[2]  = c[31:0];    s[3]  = c[63:32];
        s[4]  = c[95:64];   s[5]  = c[127:96];  s[6]  = m[95:64];   s[7]  = m[127:96];
        s[8]  = m[159:128]; s[9]  = m[191:160]; s[10] = c[159:128]; s[11] = c[191:160];
        s[12] = c[223:192]; s[13] = c[255:224]; s[14] = m[223:192]; s[15] = m[255:224];
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ al[32*i +: 32];
            s[1] = s[1] ^ 32'(r);
            for (int col = 0; col < 4; col++) begin
                for (int bt = 0; bt < 32; bt++) begin
                    v = sb_tbl[{s[col+12][bt], s[col+8][bt], s[col+4][bt], s[col][bt]}];
                    t[col][bt]    = v[0];
                    t[col+4][bt]  = v[1];
                    t[col+8][bt]  = v[2];
                    t[col+12][bt] = v[3];
                end
            end
            for (int q = 0; q < 4; q++) begin
                ia = q; ib = 4 + (q + 1) % 4; ic = 8 + (q + 2) % 4; id = 12 + (q + 3) % 4;
                a = t[ia]; b = t[ib]; cc = t[ic]; d = t[id];
                a  = rol(a, 13);
                cc = rol(cc, 3);
                b  = b ^ a ^ cc;
                d  = d ^ cc ^ (a << 3);
                b  = rol(b, 1);
                d  = rol(d, 7);
                a  = a ^ b ^ d;
                cc = cc ^ d ^ (b << 7);
                a  = rol(a, 5);
                cc = rol(cc, 22);
                s[ia] = a; s[ib] = b; s[ic] = cc; s[id] = d;
            end
        end
        return c ^ {s[11], s[10], s[9], s[8], s[3], s[2], s[1], s[0]};
    endfunction

    function automatic logic [255:0] pat256(input int seed);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[32*i +: 32] = (32'h9E3779B9 * 32'(seed * 8 + i + 1)) ^ 32'h5A5A0F0F;
        return p;
    endfunction

    function automatic logic [511:0] pat512(input int seed);
        return {pat256(seed * 2 + 101), pat256(seed * 2 + 100)};
    endfunction

    // Present one block at a negedge in IDLE and follow it until out_valid
    task automatic run_block(input string tag, input logic [255:0] m, input logic [255:0] iv,
                             input logic first, input logic fin);
        int           lat;
        int           r;
        logic         rdy_low;
        logic [255:0] c;
        logic [255:0] expv;
        check({tag, "_rdy"}, 256'(in_ready), 256'(1));
        c    = first ? iv : model_h;
        r    = fin ? 6 : 3;
        expv = model_compress(m, c, fin ? alpha_f : alpha_n, r);
        in_valid = 1'b1; exp_in = m; iv_in = iv; in_first = first; in_final = fin;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        rdy_low = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_low = 1'b0;
            in_valid = 1'b1; exp_in = ~m; iv_in = ~iv; in_first = ~first; in_final = ~fin;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (in_ready) rdy_low = 1'b0;
        in_valid = 1'b0;
        check({tag, "_lat"}, 256'(lat), 256'(r));
        check({tag, "_busy"}, 256'(rdy_low), 256'(1));
        check({tag, "_hash"}, hash_out, expv);
        model_h = expv;
    endtask

    // Hold DONE for some cycles (optionally with stray in_valid), then accept
    task automatic take_output(input string tag, input int stall, input logic pulse);
        logic [255:0] held;
        logic         stable;
        held   = hash_out;
        stable = 1'b1;
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            in_valid  = pulse & k[0];
            exp_in    = pat256(k + 50); iv_in = pat256(k + 60); in_first = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || hash_out !== held) stable = 1'b0;
        end
        if (stall > 0) check({tag, "_stall"}, 256'(stable), 256'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ovdrop"}, 256'(out_valid), 256'(0));
        check({tag, "_rdyback"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        int   lat;
        logic ov_seen;
        sb_tbl = '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF,
                   4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2};
        model_h    = '0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_valid7  = 1'b1;
        in_first   = 1'b1;
        in_final   = 1'b0;
        out_ready  = 1'b0;
        out_ready7 = 1'b0;
        exp_in     = {8{$urandom()}};
        iv_in      = {8{$urandom()}};
        alpha_n    = pat512(1);
        alpha_f    = pat512(2);

        // Reset for two cycles with activity on the inputs
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_valid7 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 256'(in_ready), 256'(1));
        check("rst_ovalid", 256'(out_valid), 256'(0));
        check("rst_hash", hash_out, 256'(0));

        // Normal block from IV, then a chain of two more normal blocks and a final one
        run_block("blk1", pat256(1), pat256(2), 1'b1, 1'b0);
        take_output("blk1", 0, 1'b0);
        run_block("blk2", pat256(3), pat256(9), 1'b0, 1'b0);
        take_output("blk2", 0, 1'b0);
        run_block("blk3", pat256(4), pat256(9), 1'b0, 1'b0);
        take_output("blk3", 0, 1'b0);
        run_block("blkf", pat256(5), pat256(9), 1'b0, 1'b1);
        take_output("blkf", 0, 1'b0);

        // Backpressure with stray in_valid pulses, then immediate next block
        run_block("bp", pat256(6), pat256(7), 1'b1, 1'b0);
        take_output("bp", 20, 1'b1);
        run_block("bpnext", pat256(8), pat256(7), 1'b0, 1'b0);
        take_output("bpnext", 0, 1'b0);

        // Reset in the middle of round 2
        in_valid = 1'b1; exp_in = pat256(11); iv_in = pat256(12); in_first = 1'b1; in_final = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_h = '0;
        ov_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) ov_seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_ov", 256'(ov_seen), 256'(0));
        check("midrst_hash", hash_out, 256'(0));
        run_block("postrst", pat256(13), pat256(14), 1'b1, 1'b0);
        take_output("postrst", 0, 1'b0);

        // Counter injection: zero constants, message and IV, single final block
        alpha_n = '0;
        alpha_f = '0;
        run_block("cnt6", 256'(0), 256'(0), 1'b1, 1'b1);
        take_output("cnt6", 0, 1'b0);

        // Same on the seven-round final variant
        check("cnt7_rdy", 256'(in_ready7), 256'(1));
        in_valid7 = 1'b1; exp_in = '0; iv_in = '0; in_first = 1'b1; in_final = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid7 = 1'b0;
        lat = 0;
        while (!out_valid7 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("cnt7_lat", 256'(lat), 256'(7));
        check("cnt7_hash", hash_out7, model_compress(256'(0), 256'(0), 512'(0), 7));
        out_ready7 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready7 = 1'b0;
        check("cnt7_done", 256'(out_valid7), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamsi_round_engine.md
# hamsi_round_engine

Iterative, parametrised Hamsi compression core. It accepts one expanded message block (eight 32-bit words) and forms the 16-word state by concatenation with the chaining value. It runs a configurable number of rounds, one per clock: constant/counter addition, substitution, then diffusion. It finishes with truncation and feed-forward into the internal chaining value. It sits between the message-expansion stage and the padding/output controller, and serves both normal (P) and final (Pf) compressions with different round counts.

## Interface
- `ROUNDS`, default 3: rounds for a normal compression (P).
- `ROUNDS_F`, default 6: rounds for a final compression (Pf).
- `CNT_W`, default 3: round-counter width.
  - Must satisfy 2^CNT_W ≥ max(ROUNDS, ROUNDS_F).
  - Both round parameters must be ≥ 1.
- `clk` in 1: the only clock; all registers update on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: an expanded block is presented.
- `in_ready` out 1: high only in IDLE.
- `in_first` in 1: take the chaining value from `iv_in` instead of the internal `h`.
- `in_final` in 1: run `ROUNDS_F` rounds with `alpha_f`.
- `exp_in` in 256: expanded words m0..m7, with m0 in [31:0].
- `iv_in` in 256: initial chaining value c0..c7, with c0 in [31:0].
- `alpha_n` in 512: P constants α0..α15, with α0 in [31:0]; quasi-static.
- `alpha_f` in 512: Pf constants, same layout as `alpha_n`.
- `out_valid` out 1: `hash_out` holds the updated chaining value.
- `out_ready` in 1: the consumer accepts the result.
- `hash_out` out 256: chaining value register `h`, with h0 in [31:0].

## Operation
- **State:** s0..s15 (32 bits each), `h` (256 bits), FSM, round counter `cnt` (CNT_W bits), latched mode bit `fin`.
- **FSM:** IDLE → ROUND → DONE → IDLE.
- **IDLE:** `in_ready`=1.
  - On `in_valid`: let c = `in_first` ? `iv_in` : `h`.
  - Load s = (m0,m1,c0,c1, c2,c3,m2,m3, m4,m5,c4,c5, c6,c7,m6,m7).
  - Copy c into `h`, set `fin`=`in_final`, clear `cnt`, go to ROUND.
- **ROUND, each cycle:** s ← L(S(A(s))).
  - **A (addition):** si ^= αi, where α = `fin` ? `alpha_f` : `alpha_n`. In addition, s1 ^= zero-extended `cnt`.
  - **S (substitution):** the existing SUBSTITUTION block applied to each column (si, si+4, si+8, si+12) for i = 0..3. Outputs 0..3 write back to the same positions.
    - Check value: input (0,0,0,0) gives output (0,0,0,FFFFFFFF).
  - **L (diffusion):** the existing DIFFUSION block applied to quadruples (s0,s5,s10,s15), (s1,s6,s11,s12), (s2,s7,s8,s13), (s3,s4,s9,s14), in (a,b,c,d) order.
    - Rotates: 13, 3, 1, 7, 5, 22. Shifts: 3, 7.
  - `cnt` increments each round.
- **Last round:** when `cnt` = R−1, with R = `fin` ? ROUNDS_F : ROUNDS:
  - Compute s' as usual.
  - Set `h` ← `h` ^ (s'0,s'1,s'2,s'3,s'8,s'9,s'10,s'11).
  - Go to DONE.
- **DONE:** `out_valid`=1 and `hash_out`=`h`, stable until `out_ready`.
  - On `out_ready`: go to IDLE.
  - `h` is retained for the next block.
- Counter arithmetic is modulo 2^CNT_W; it never wraps within a legal configuration.
- `in_*` inputs outside IDLE are ignored. `alpha_*` must not change between acceptance and DONE.

## Timing
- **Reset values:**
  - FSM = IDLE, so `in_ready`=1 from the first cycle after reset.
  - `out_valid`=0.
  - `h`, s, `cnt`, `fin` = 0, so `hash_out`=0.
- **Latency:** accept at edge t; round k occupies cycle t+k for k = 1..R. `out_valid` is first high in cycle t+R+1.
- **Throughput:** one block per R+2 cycles at minimum (with `out_ready` held high). `in_ready`=0 in the cycle `out_valid` is accepted, so acceptance is back-to-back-minus-one.
- **Stall:** DONE persists for any number of cycles while `out_ready`=0, with no change to `hash_out`.
- **`in_valid` during ROUND or DONE:** ignored. The upstream stage must hold its data until `in_ready`.
- **`rst` mid-ROUND or mid-DONE:** aborts the operation next edge.
  - All state returns to its reset values, and `out_valid` drops.
  - No partial `h` update is visible.
  - `rst` has priority over every other event.
- **`in_first` and `in_final` together:** legal (single-block message). Pf runs with `iv_in` as the chaining value.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → `in_ready`=1, `out_valid`=0, `hash_out`=0 in the cycle after release.
- **Normal-block latency:** ROUNDS=3; accept at cycle 10 with `in_first`=1 → `out_valid` rises at cycle 14; `hash_out` equals the C golden model of h ^ T(P(s)); `in_ready`=0 during cycles 11-14.
- **Chaining:** three blocks, then a final block (`in_first` on the first block only, `in_final` on the last) → each `hash_out` matches the golden model. The final block's `out_valid` comes 7 cycles after acceptance (ROUNDS_F=6).
- **Backpressure:** hold `out_ready`=0 for 20 cycles in DONE → `hash_out` is stable; `in_valid` pulses are ignored; a new block is accepted the cycle after `out_ready`.
- **Reset mid-ROUND:** assert `rst` in round 2 → `out_valid` never rises and `h`=0. A subsequent block with `in_first`=1 matches the golden model.
- **Counter injection:** α=0, m=0, iv=0, `in_final`=1 → result matches the golden model only if `cnt` 0..5 is XORed into s1 alone. The bench also checks a variant with ROUNDS_F=7, CNT_W=3.
